// File: rtl/phys_reg_free_list_mw_if.sv
// Rename/retire/checkpoint bus of the multi-way physical register free list.
// master = rename/retire/branch side, slave = free list.
interface phys_reg_free_list_mw_if #(
  parameter int unsigned NUM_PHYS_REGS   = 64,
  parameter int unsigned DEQ_WIDTH       = 2,
  parameter int unsigned ENQ_WIDTH       = 2,
  parameter int unsigned NUM_CHECKPOINTS = 4,
  parameter int unsigned ROB_IDX_W       = 5
);
  localparam int unsigned TAG_W = $clog2(NUM_PHYS_REGS);
  localparam int unsigned CP_W  = $clog2(NUM_CHECKPOINTS);

  logic [DEQ_WIDTH-1:0]              dequeue_tag_valid;
  logic [DEQ_WIDTH-1:0][TAG_W-1:0]   dequeue_tag;
  logic [DEQ_WIDTH-1:0]              dequeue_valid;
  logic [ENQ_WIDTH-1:0]              enqueue_valid;
  logic [ENQ_WIDTH-1:0][TAG_W-1:0]   enqueue_tag;
  logic                              save_checkpoint_valid;
  logic [ROB_IDX_W-1:0]              save_checkpoint_ROB_index;
  logic                              save_checkpoint_ready;
  logic [CP_W-1:0]                   save_checkpoint_column;
  logic                              restore_checkpoint_valid;
  logic                              restore_checkpoint_speculate_failed;
  logic [CP_W-1:0]                   restore_checkpoint_column;
  logic [ROB_IDX_W-1:0]              restore_checkpoint_ROB_index;
  logic                              restore_checkpoint_success;

  modport master (
    input  dequeue_tag_valid, dequeue_tag, save_checkpoint_ready,
           save_checkpoint_column, restore_checkpoint_success,
    output dequeue_valid, enqueue_valid, enqueue_tag,
           save_checkpoint_valid, save_checkpoint_ROB_index,
           restore_checkpoint_valid, restore_checkpoint_speculate_failed,
           restore_checkpoint_column, restore_checkpoint_ROB_index
  );

  modport slave (
    output dequeue_tag_valid, dequeue_tag, save_checkpoint_ready,
           save_checkpoint_column, restore_checkpoint_success,
    input  dequeue_valid, enqueue_valid, enqueue_tag,
           save_checkpoint_valid, save_checkpoint_ROB_index,
           restore_checkpoint_valid, restore_checkpoint_speculate_failed,
           restore_checkpoint_column, restore_checkpoint_ROB_index
  );
endinterface

// File: rtl/phys_reg_free_list_mw.sv
// Multi-way physical register free list: circular tag array with wrap-bit pointers
// and a checkpoint ring of saved head pointers for single-cycle mispredict rollback.
module phys_reg_free_list_mw #(
  parameter int unsigned NUM_PHYS_REGS   = 64,
  parameter int unsigned NUM_ARCH_REGS   = 32,
  parameter int unsigned DEQ_WIDTH       = 2,
  parameter int unsigned ENQ_WIDTH       = 2,
  parameter int unsigned NUM_CHECKPOINTS = 4,
  parameter int unsigned ROB_IDX_W       = 5
) (
  input  logic                    CLK,
  input  logic                    nRST,
  phys_reg_free_list_mw_if.slave  bus
);
  localparam int unsigned TAG_W     = $clog2(NUM_PHYS_REGS);
  localparam int unsigned CP_W      = $clog2(NUM_CHECKPOINTS);
  localparam int unsigned PTR_W     = TAG_W + 1;
  localparam int unsigned CPP_W     = CP_W + 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

  logic [TAG_W-1:0]     entry_q     [NUM_PHYS_REGS];
  logic [TAG_W-1:0]     entry_d     [NUM_PHYS_REGS];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CPP_W-1:0]     cp_head_q, cp_head_d, cp_tail_q, cp_tail_d;
  logic [NUM_CHECKPOINTS-1:0] cp_valid_q, cp_valid_d;
  logic [PTR_W-1:0]     cp_saved_q  [NUM_CHECKPOINTS];
  logic [PTR_W-1:0]     cp_saved_d  [NUM_CHECKPOINTS];
  logic [ROB_IDX_W-1:0] cp_rob_q    [NUM_CHECKPOINTS];
  logic [ROB_IDX_W-1:0] cp_rob_d    [NUM_CHECKPOINTS];

  logic [PTR_W-1:0]     free_count;
  logic [PTR_W-1:0]     deq_cnt;
  logic                 deq_run;
  logic [PTR_W-1:0]     enq_cnt;
  logic [DEQ_WIDTH-1:0] tag_valid_c;
  logic [DEQ_WIDTH-1:0][TAG_W-1:0] tag_c;
  logic                 cp_full;
  logic [CP_W-1:0]      rst_col;
  logic                 col_match;
  logic                 rollback_ok;
  logic                 release_ok;
  logic                 save_fire;
  logic [CP_W-1:0]      rb_off;
  logic [CPP_W-1:0]     rb_tail;
  logic [CPP_W-1:0]     inv_cnt;

  assign free_count = tail_q - head_q;

  // Dequeue lanes: only the leading run of requested, available lanes is consumed.
  always_comb begin
    deq_cnt     = '0;
    deq_run     = 1'b1;
    tag_valid_c = '0;
    tag_c       = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      tag_valid_c[i] = free_count > PTR_W'(i);
      tag_c[i]       = entry_q[TAG_W'(head_q[TAG_W-1:0] + TAG_W'(i))];
      if (deq_run && bus.dequeue_valid[i] && tag_valid_c[i]) begin
        deq_cnt = deq_cnt + PTR_W'(1);
      end else begin
        deq_run = 1'b0;
      end
    end
  end

  // Checkpoint ring status and restore qualification.
  assign cp_full     = (cp_tail_q[CP_W] != cp_head_q[CP_W]) &&
                       (cp_tail_q[CP_W-1:0] == cp_head_q[CP_W-1:0]);
  assign rst_col     = bus.restore_checkpoint_column;
  assign col_match   = cp_valid_q[rst_col] &&
                       (cp_rob_q[rst_col] == bus.restore_checkpoint_ROB_index);
  assign rollback_ok = bus.restore_checkpoint_valid && bus.restore_checkpoint_speculate_failed &&
                       col_match;
  assign release_ok  = bus.restore_checkpoint_valid && !bus.restore_checkpoint_speculate_failed &&
                       col_match && (rst_col == cp_head_q[CP_W-1:0]);
  assign save_fire   = bus.save_checkpoint_valid && !cp_full && !rollback_ok;

  // Rollback truncates the ring back to the target column, keeping its wrap bit
  // consistent by measuring the target's distance from cp_head.
  assign rb_off  = CP_W'(rst_col - cp_head_q[CP_W-1:0]);
  assign rb_tail = cp_head_q + CPP_W'(rb_off);
  assign inv_cnt = cp_tail_q - rb_tail;

  always_comb begin
    entry_d    = entry_q;
    head_d     = head_q + deq_cnt;
    tail_d     = tail_q;
    cp_head_d  = cp_head_q;
    cp_tail_d  = cp_tail_q;
    cp_valid_d = cp_valid_q;
    cp_saved_d = cp_saved_q;
    cp_rob_d   = cp_rob_q;
    enq_cnt    = '0;

    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (bus.enqueue_valid[i]) begin
        entry_d[TAG_W'(tail_q[TAG_W-1:0] + enq_cnt[TAG_W-1:0])] = bus.enqueue_tag[i];
        enq_cnt = enq_cnt + PTR_W'(1);
      end
    end
    tail_d = tail_q + enq_cnt;

    if (save_fire) begin
      cp_valid_d[cp_tail_q[CP_W-1:0]] = 1'b1;
      cp_saved_d[cp_tail_q[CP_W-1:0]] = head_q + deq_cnt;
      cp_rob_d[cp_tail_q[CP_W-1:0]]   = bus.save_checkpoint_ROB_index;
      cp_tail_d                       = cp_tail_q + CPP_W'(1);
    end

    if (release_ok) begin
      cp_valid_d[rst_col] = 1'b0;
      cp_head_d           = cp_head_q + CPP_W'(1);
    end

    if (rollback_ok) begin
      head_d    = cp_saved_q[rst_col];
      cp_tail_d = rb_tail;
      for (int j = 0; j < NUM_CHECKPOINTS; j++) begin
        if (CPP_W'(CP_W'(CP_W'(j) - rst_col)) < inv_cnt) begin
          cp_valid_d[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q     <= '0;
      tail_q     <= PTR_W'(INIT_FREE);
      cp_head_q  <= '0;
      cp_tail_q  <= '0;
      cp_valid_q <= '0;
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        if (i < int'(INIT_FREE)) entry_q[i] <= TAG_W'(NUM_ARCH_REGS + i);
        else                     entry_q[i] <= '0;
      end
      for (int j = 0; j < NUM_CHECKPOINTS; j++) begin
        cp_saved_q[j] <= '0;
        cp_rob_q[j]   <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cp_head_q  <= cp_head_d;
      cp_tail_q  <= cp_tail_d;
      cp_valid_q <= cp_valid_d;
      entry_q    <= entry_d;
      cp_saved_q <= cp_saved_d;
      cp_rob_q   <= cp_rob_d;
    end
  end

  assign bus.dequeue_tag_valid          = tag_valid_c;
  assign bus.dequeue_tag                = tag_c;
  assign bus.save_checkpoint_ready      = !cp_full;
  assign bus.save_checkpoint_column     = cp_tail_q[CP_W-1:0];
  assign bus.restore_checkpoint_success = rollback_ok || release_ok;

  // Retire may never free more tags than the array can hold.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!nRST)
    (CNT_W'(free_count) + CNT_W'(enq_cnt)) <= CNT_W'(NUM_PHYS_REGS));

endmodule

// File: tb/tb_phys_reg_free_list_mw.sv
// Scoreboard bench for phys_reg_free_list_mw: expectations are queued as stimulus
// is driven and popped/compared at the falling edge of the same cycle.
module tb_phys_reg_free_list_mw;
  logic clk;
  logic nrst;

  typedef enum int {K_VLD, K_T0, K_T1, K_RDY, K_COL, K_SUC} kind_e;
  typedef struct {
    kind_e k;
    int    v;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;

  phys_reg_free_list_mw_if bus ();

  phys_reg_free_list_mw dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int observe(input kind_e k);
    case (k)
      K_VLD:   return int'(bus.dequeue_tag_valid);
      K_T0:    return int'(bus.dequeue_tag[0]);
      K_T1:    return int'(bus.dequeue_tag[1]);
      K_RDY:   return int'(bus.save_checkpoint_ready);
      K_COL:   return int'(bus.save_checkpoint_column);
      default: return int'(bus.restore_checkpoint_success);
    endcase
  endfunction

  task automatic exp_out(input kind_e k, input int v);
    exp_t e;
    e.k = k;
    e.v = v;
    sb_q.push_back(e);
  endtask

  task automatic exp_lanes(input int vld, input int t0, input int t1);
    exp_out(K_VLD, vld);
    exp_out(K_T0, t0);
    exp_out(K_T1, t1);
  endtask

  task automatic clear_inputs();
    bus.dequeue_valid                       = '0;
    bus.enqueue_valid                       = '0;
    bus.enqueue_tag                         = '0;
    bus.save_checkpoint_valid               = 1'b0;
    bus.save_checkpoint_ROB_index           = '0;
    bus.restore_checkpoint_valid            = 1'b0;
    bus.restore_checkpoint_speculate_failed = 1'b0;
    bus.restore_checkpoint_column           = '0;
    bus.restore_checkpoint_ROB_index        = '0;
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.k.name(), observe(e.k), e.v);
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic dq(input logic [1:0] v);
    bus.dequeue_valid = v;
  endtask

  task automatic save(input int rob);
    bus.save_checkpoint_valid     = 1'b1;
    bus.save_checkpoint_ROB_index = 5'(rob);
  endtask

  task automatic restore(input logic failed, input int col, input int rob);
    bus.restore_checkpoint_valid            = 1'b1;
    bus.restore_checkpoint_speculate_failed = failed;
    bus.restore_checkpoint_column           = 2'(col);
    bus.restore_checkpoint_ROB_index        = 5'(rob);
  endtask

  // Asynchronous mid-run reset; outputs must snap back before any clock edge.
  task automatic do_reset();
    nrst = 1'b0;
    #2;
    check_val("async_rst_tag0", int'(bus.dequeue_tag[0]), 32);
    check_val("async_rst_vld", int'(bus.dequeue_tag_valid), 3);
    #2;
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk   = 1'b0;
    nrst  = 1'b0;
    total = 0;
    bad   = 0;
    clear_inputs();
    #12;
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Reset outputs.
    exp_lanes(3, 32, 33);
    exp_out(K_RDY, 1);
    exp_out(K_COL, 0);
    exp_out(K_SUC, 0);
    step();

    // Drain all 32 free tags two per cycle.
    for (int k = 0; k < 16; k++) begin
      dq(2'b11);
      exp_lanes(3, 32 + 2*k, 33 + 2*k);
      step();
    end
    // Empty: dequeue ignored, same-cycle enqueue not bypassed.
    dq(2'b11);
    bus.enqueue_valid  = 2'b11;
    bus.enqueue_tag[0] = 6'd5;
    bus.enqueue_tag[1] = 6'd7;
    exp_out(K_VLD, 0);
    step();
    exp_lanes(3, 5, 7);
    step();

    do_reset();

    // Save after two dequeues, dequeue four more, roll back.
    dq(2'b11);
    save(3);
    exp_lanes(3, 32, 33);
    exp_out(K_RDY, 1);
    exp_out(K_COL, 0);
    step();
    dq(2'b11);
    exp_lanes(3, 34, 35);
    exp_out(K_COL, 1);
    step();
    dq(2'b11);
    exp_lanes(3, 36, 37);
    step();
    restore(1'b1, 0, 3);
    dq(2'b11);
    exp_out(K_SUC, 1);
    exp_lanes(3, 38, 39);
    step();

    // Restored head visible next cycle; ring back to column 0.
    save(3);
    exp_lanes(3, 34, 35);
    exp_out(K_COL, 0);
    step();
    restore(1'b1, 0, 4);
    exp_out(K_SUC, 0);
    exp_out(K_COL, 1);
    step();
    restore(1'b0, 1, 3);
    exp_out(K_SUC, 0);
    exp_lanes(3, 34, 35);
    step();
    restore(1'b0, 0, 3);
    exp_out(K_SUC, 1);
    step();
    restore(1'b1, 0, 3);
    exp_out(K_SUC, 0);
    exp_out(K_COL, 1);
    step();

    do_reset();

    // Fill the ring while dequeuing; saved heads are 2,4,6,8.
    for (int c = 0; c < 4; c++) begin
      dq(2'b11);
      save(10 + c);
      exp_out(K_RDY, 1);
      exp_out(K_COL, c);
      exp_lanes(3, 32 + 2*c, 33 + 2*c);
      step();
    end
    save(14);
    restore(1'b0, 0, 10);
    exp_out(K_RDY, 0);
    exp_out(K_COL, 0);
    exp_out(K_SUC, 1);
    exp_lanes(3, 40, 41);
    step();
    restore(1'b1, 0, 14);
    exp_out(K_RDY, 1);
    exp_out(K_COL, 0);
    exp_out(K_SUC, 0);
    step();

    // Rollback to column 1 with dequeue, save and enqueue in the same cycle.
    restore(1'b1, 1, 11);
    dq(2'b11);
    save(20);
    bus.enqueue_valid  = 2'b01;
    bus.enqueue_tag[0] = 6'd9;
    exp_out(K_SUC, 1);
    exp_lanes(3, 40, 41);
    step();
    exp_out(K_COL, 1);
    exp_out(K_RDY, 1);
    for (int k = 0; k < 14; k++) begin
      dq(2'b11);
      exp_lanes(3, 36 + 2*k, 37 + 2*k);
      step();
    end
    // Single remaining tag is the enqueued 9; only lane 0 honoured.
    dq(2'b11);
    exp_out(K_VLD, 1);
    exp_out(K_T0, 9);
    step();
    restore(1'b1, 1, 20);
    exp_out(K_VLD, 0);
    exp_out(K_SUC, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phys_reg_free_list_mw.md
# phys_reg_free_list_mw

Multi-way physical register free list with checkpoint ring. It supplies up to DEQ_WIDTH free physical register tags per cycle to rename and accepts up to ENQ_WIDTH freed tags per cycle from retire. The head pointer is checkpointed at each speculation point. On a mispredict the head is rolled back, so every tag dequeued after that point becomes free again in a single cycle. The block sits in core between decode/rename, the ROB retire path and the branch restore system.

## Interface
- NUM_PHYS_REGS, 64, total physical registers; free list depth; power of two
- NUM_ARCH_REGS, 32, tags 0..NUM_ARCH_REGS-1 are mapped at reset and are never in the free list at reset
- DEQ_WIDTH, 2, rename lanes per cycle
- ENQ_WIDTH, 2, retire free lanes per cycle
- NUM_CHECKPOINTS, 4, checkpoint ring depth; power of two
- ROB_IDX_W, 5, ROB index width
- TAG_W = clog2(NUM_PHYS_REGS); CP_W = clog2(NUM_CHECKPOINTS) (derived, not overridable)
- CLK  in  1  clock; all state on rising edge
- nRST  in  1  asynchronous active-low reset
- dequeue_tag_valid  out  DEQ_WIDTH  lane i has a tag (free_count > i)
- dequeue_tag  out  DEQ_WIDTH×TAG_W  lane i = entry[head+i]
- dequeue_valid  in  DEQ_WIDTH  lane i consumes its tag
- enqueue_valid  in  ENQ_WIDTH  lane i frees a tag
- enqueue_tag  in  ENQ_WIDTH×TAG_W  freed tags
- save_checkpoint_valid  in  1  take a checkpoint this cycle
- save_checkpoint_ROB_index  in  ROB_IDX_W  tag stored with the checkpoint
- save_checkpoint_ready  out  1  ring not full
- save_checkpoint_column  out  CP_W  column the save writes (ring tail)
- restore_checkpoint_valid  in  1  restore/release request
- restore_checkpoint_speculate_failed  in  1  1 = rollback, 0 = release
- restore_checkpoint_column  in  CP_W  target column
- restore_checkpoint_ROB_index  in  ROB_IDX_W  must match the stored tag
- restore_checkpoint_success  out  1  request accepted

## Operation
- Storage: circular array of NUM_PHYS_REGS tags.
- head and tail are TAG_W+1 bits, the MSB being the wrap bit.
- free_count = tail − head, range 0..NUM_PHYS_REGS.
- Dequeue: only the contiguous prefix of dequeue_valid starting at lane 0 that is also dequeue_tag_valid is honoured. Higher lanes are ignored. head += honoured count.
- Enqueue: valid lanes are compacted in lane order and written to entry[tail], entry[tail+1], and so on. tail += popcount.
- Enqueue with free_count + popcount > NUM_PHYS_REGS is illegal and is flagged by an assertion.
- Checkpoint ring: CP_W+1-bit cp_head/cp_tail. Per column: valid bit, saved head, ROB tag.
- Save: applies when save_checkpoint_valid && save_checkpoint_ready.
  - Writes column cp_tail with valid=1, the ROB tag, and saved head = head after this cycle's dequeues.
  - cp_tail++.
- Restore, failed (speculate_failed=1):
  - success = column valid && stored ROB tag == input ROB index.
  - On success: head ← saved head. Columns from the target through cp_tail−1 are invalidated. cp_tail ← target column (keeping the wrap bit consistent).
  - Same-cycle dequeues and saves are discarded. Same-cycle enqueues still apply.
- Release (speculate_failed=0):
  - success = target == cp_head column && valid && ROB tag match.
  - On success the column is invalidated and cp_head++. Dequeue and save proceed normally.
- success=0 means no state change from the restore request.

## Timing
- All outputs are combinational from registered state plus current inputs. All updates are visible the next cycle.
- Restore-to-dequeue latency: 1 cycle. The cycle after a rollback, dequeue_tag shows the restored head.
- Reset values:
  - head=0; tail=NUM_PHYS_REGS−NUM_ARCH_REGS, wrap bit 0.
  - entry[i] = NUM_ARCH_REGS+i for i < NUM_PHYS_REGS−NUM_ARCH_REGS, else 0.
  - cp_head=cp_tail=0; all columns invalid.
- Outputs at reset: dequeue_tag_valid all 1; dequeue_tag = {33,32}; save_checkpoint_ready=1; save_checkpoint_column=0; restore_checkpoint_success=0.
- Empty (free_count=0): all dequeue_tag_valid=0; dequeue is a no-op; enqueues in the same cycle are not bypassed to dequeue.
- Ring full: save_checkpoint_ready=0 and the save is ignored. A release in the same cycle does not make the ring ready that cycle.
- Pointer wrap is modulo the array depth via the wrap bit. free_count==NUM_PHYS_REGS is legal.
- nRST asserted mid-operation returns all state to reset values asynchronously.

## Test plan
- Reset, then sample outputs -> tags {33,32}, both valid, ready=1, column 0, success=0, free_count=32.
- 16 cycles of dual dequeue, then 1 cycle -> empty: valid=00, head wrap-clean; next cycle enqueue {5,7} -> dequeue_tag lane0=5, lane1=7.
- Dequeue 2, save (ROB 3) -> column 0; dequeue 4 more; rollback column 0, ROB 3 -> success=1; next cycle dequeue_tag lane0=34, free_count=30.
- Rollback column 0 with ROB 4 (stored 3) -> success=0, head unchanged; release column 1 when oldest is column 0 -> success=0.
- Fill 4 checkpoints -> ready=0, fifth save ignored; release column 0 -> next cycle ready=1, column=0.
- In one cycle, successful rollback + dual dequeue + save + enqueue {9} -> head=saved, tail+1, no new checkpoint, entry[old tail]=9.
